// File: rtl/sched_buffer_issuer.sv
// sched_buffer_issuer: cache-side initiator for the DRAM scheduler buffer.
// Stages read/write requests in a small FIFO and issues them one per cycle
// against a credit counter sized to the scheduler queue. Completions are
// retired through a three-state handshake (WAIT -> DONE -> RESP).
// Optional macro ISSUER_CALLBACK_CHECK_EN adds an in-order tracker that
// flags scheduler callback addresses that disagree with issue order.
module sched_buffer_issuer #(
   parameter int unsigned WORD_W      = 32,
   parameter int unsigned DEPTH       = 4,
   parameter int unsigned SCHED_DEPTH = 8
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              req_ren,
   input  logic              req_wen,
   input  logic [WORD_W-1:0] req_addr,
   input  logic [WORD_W-1:0] req_wdata,
   output logic              req_ready,
   output logic              dREN,
   output logic              dWEN,
   output logic [WORD_W-1:0] ramaddr,
   output logic [WORD_W-1:0] memstore,
   output logic              request_done,
   input  logic [WORD_W-1:0] memaddr_callback,
   input  logic              dram_done,
   input  logic [WORD_W-1:0] dram_rdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [WORD_W-1:0] resp_addr,
   output logic [WORD_W-1:0] resp_rdata,
   output logic              overrun_err,
   output logic              cb_err
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(SCHED_DEPTH + 1);
   localparam logic [AW:0]   PTR_ONE  = (AW + 1)'(1);
   localparam logic [CW-1:0] CRED_ONE = CW'(1);
   localparam logic [CW-1:0] CRED_MAX = CW'(SCHED_DEPTH);

   typedef enum logic [1:0] {ST_WAIT, ST_DONE, ST_RESP} state_t;

   logic              fifo_wen  [DEPTH];
   logic [WORD_W-1:0] fifo_addr [DEPTH];
   logic [WORD_W-1:0] fifo_data [DEPTH];
   logic [AW:0]       wr_ptr, rd_ptr;
   logic [CW-1:0]     credits;
   logic              empty, full, push, pop;
   state_t            state;

   assign empty     = (wr_ptr == rd_ptr);
   assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign req_ready = !full;
   assign push      = (req_ren | req_wen) & req_ready;
   assign pop       = !empty && (credits != '0);

   // Staging FIFO storage; contents need no reset since pointers gate them
   always_ff @(posedge CLK) begin
      if (push) begin
         fifo_wen[wr_ptr[AW-1:0]]  <= req_wen;
         fifo_addr[wr_ptr[AW-1:0]] <= req_addr;
         fifo_data[wr_ptr[AW-1:0]] <= req_wdata;
      end
   end

   // Staging FIFO pointers, extra MSB distinguishes full from empty
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   // Registered issue: pulse dREN/dWEN the cycle after the head is popped
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         dREN     <= 1'b0;
         dWEN     <= 1'b0;
         ramaddr  <= '0;
         memstore <= '0;
      end else begin
         dREN <= pop && !fifo_wen[rd_ptr[AW-1:0]];
         dWEN <= pop &&  fifo_wen[rd_ptr[AW-1:0]];
         if (pop) begin
            ramaddr <= fifo_addr[rd_ptr[AW-1:0]];
            if (fifo_wen[rd_ptr[AW-1:0]]) memstore <= fifo_data[rd_ptr[AW-1:0]];
         end
      end
   end

   // Credit counter: issue consumes, retire returns, saturating at capacity
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         credits <= CRED_MAX;
      end else begin
         case ({pop, request_done})
            2'b10:   credits <= credits - CRED_ONE;
            2'b01:   if (credits < CRED_MAX) credits <= credits + CRED_ONE;
            default: credits <= credits;
         endcase
      end
   end

   // Completion FSM with registered request_done / response outputs
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state        <= ST_WAIT;
         request_done <= 1'b0;
         resp_valid   <= 1'b0;
         resp_addr    <= '0;
         resp_rdata   <= '0;
         overrun_err  <= 1'b0;
      end else begin
         request_done <= 1'b0;
         if (dram_done && state != ST_WAIT) overrun_err <= 1'b1;
         case (state)
            ST_WAIT: begin
               if (dram_done) begin
                  resp_rdata   <= dram_rdata;
                  request_done <= 1'b1;
                  state        <= ST_DONE;
               end
            end
            ST_DONE: begin
               resp_addr  <= memaddr_callback;
               resp_valid <= 1'b1;
               state      <= ST_RESP;
            end
            ST_RESP: begin
               if (resp_ready) begin
                  resp_valid <= 1'b0;
                  state      <= ST_WAIT;
               end
            end
            default: state <= ST_WAIT;
         endcase
      end
   end

`ifdef ISSUER_CALLBACK_CHECK_EN
   localparam int unsigned TW = $clog2(SCHED_DEPTH);
   localparam logic [TW:0] TR_ONE = (TW + 1)'(1);

   logic [WORD_W-1:0] tr_mem [SCHED_DEPTH];
   logic [TW:0]       tr_wr, tr_rd;
   logic              tr_empty;

   assign tr_empty = (tr_wr == tr_rd);

   // Tracker storage: record each issued address in issue order
   always_ff @(posedge CLK) begin
      if (pop) tr_mem[tr_wr[TW-1:0]] <= fifo_addr[rd_ptr[AW-1:0]];
   end

   // Tracker pointers and sticky mismatch flag; credits bound occupancy
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         tr_wr  <= '0;
         tr_rd  <= '0;
         cb_err <= 1'b0;
      end else begin
         if (pop) tr_wr <= tr_wr + TR_ONE;
         if (request_done) begin
            if (tr_empty) begin
               cb_err <= 1'b1;
            end else begin
               tr_rd <= tr_rd + TR_ONE;
               if (memaddr_callback != tr_mem[tr_rd[TW-1:0]]) cb_err <= 1'b1;
            end
         end
      end
   end
`else
   assign cb_err = 1'b0;
`endif

endmodule
